jpeg_stream_mux: RTL and testbench
==================================

Name: jpeg_stream_mux

Overview:
- Parametrised multi-channel successor to the per-channel entropy-coder output stage.
- Consumes the variable-length code words produced by CH independent colour-channel coders.
- Interleaves them per MCU according to a runtime chroma-subsampling mode (4:4:4 / 4:2:2 / 4:2:0) and packs them MSB-first into a byte stream.
- Applies JPEG 0xFF byte stuffing, and on request pads the final byte and appends the EOI marker. It sits between the EntropyCoder instances and the output byte FIFO/DMA.

Parameters:
- CH, 3, number of input channels; channel 0 is luma, channels 1..CH-1 are chroma.
- CODE_W, 27, maximum code-word width (16-bit Huffman + 11-bit amplitude).
- LEN_W, 5, width of the length field; must satisfy 2^LEN_W > CODE_W.
- ACC_W, 64, bit-accumulator width; must be at least CODE_W+8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- mode  in  2  subsampling mode: 0=4:4:4 (1 Y block per MCU), 1=4:2:2 (2 Y), 2=4:2:0 (4 Y), 3=reserved (treated as 0). Sampled only in IDLE when in_valid is first seen.
- in_valid  in  CH  per-channel code-word valid.
- in_ready  out  CH  per-channel accept.
- in_code  in  CH*CODE_W  per-channel code word, right-aligned.
- in_len  in  CH*LEN_W  per-channel valid bit count, 0..CODE_W.
- in_eob  in  CH  marks the last code word of an 8x8 block.
- frame_end  in  1  pulse: finish the frame after the current MCU.
- out_valid  out  1  byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  stream byte.
- out_last  out  1  high with the 0xD9 EOI byte.
- busy  out  1  high outside IDLE.

Interface: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0. This includes in_ready, out_valid, out_data, out_last and busy. State=IDLE, accumulator count=0, schedule pointer=0, pending-end flag=0.
- Handshakes:
  - Input transfer on in_valid[c]&in_ready[c].
  - Output transfer on out_valid&out_ready.
  - out_data/out_valid/out_last must hold stable while out_valid&!out_ready.
- Schedule:
  - Per MCU: Y repeated NY times (NY=1/2/4 for mode 0/1/2), then channels 1..CH-1 once each.
  - Only the scheduled channel's in_ready may be high; all others are 0.
  - The schedule advances on an accepted word with in_eob=1. It wraps to Y at MCU end.
- Packing:
  - An accepted word appends in_code[in_len-1:0] MSB-first to the accumulator.
  - in_len=0 is accepted and adds no bits (the block still advances if in_eob).
  - in_ready[c] = (state==RUN) && (count+CODE_W <= ACC_W) && scheduled channel == c.
- Byte emitter:
  - Whenever count>=8 and no stuff byte is pending, present the top 8 bits.
  - If the byte was 0xFF, the next output byte is forced to 0x00 (stuff) before further data.
  - Emitter and packer operate in the same cycle. Accept-to-first-byte latency is 1 cycle.
- FSM:
  - IDLE -> RUN on any in_valid (mode latched).
  - RUN -> FLUSH at an MCU boundary with pending-end set. frame_end may arrive mid-MCU; it is latched and honoured at the boundary. frame_end at a boundary with no MCU started goes straight to FLUSH.
  - FLUSH: pad with 1-bits to a byte boundary (no pad if count%8==0) and drain all bytes, stuffing included.
  - MARKER_FF: emit 0xFF, with no stuffing after a marker.
  - MARKER_D9: emit 0xD9 with out_last=1, then go to IDLE and clear the pointer.
- frame_end in IDLE (no data): emit FF D9 only.
- A second frame_end while pending is ignored.
- Asynchronous reset mid-frame discards the accumulator and pending bytes; no EOI is produced.

Decomposition:
- Shared package jpeg_stream_pkg holds:
  - mode enum (MODE_444, MODE_422, MODE_420);
  - marker constants (MARKER_PREFIX=8'hFF, EOI=8'hD9, STUFF=8'h00);
  - FSM state enum;
  - a function ny_of_mode(mode).
- One natural sub-module, bit_packer: accumulator, append, byte extraction and stuffing, with its own valid/ready output.

Test Plan:
- 4:4:4, CH=3: Y {code=0b1010, len=4, eob}, Cb {0b0101, 4, eob}, Cr {0xFF, 8, eob}, then frame_end -> bytes A5 FF 00 FF D9, out_last on D9.
- 4:2:0: offer Cb valid before the 4th Y eob -> in_ready[1] stays 0 until four Y eobs are accepted. Order is verified as Y,Y,Y,Y,Cb,Cr.
- Partial byte: single Y {0b101, 3, eob}, Cb/Cr len 0 with eob, frame_end -> BF FF D9 (pad 1s).
- Backpressure: out_ready=0 for 20 cycles with words streaming -> in_ready drops once count+27>64. No byte is lost or changed; out_data is stable while stalled.
- frame_end in IDLE -> exactly FF D9, busy 1 for the duration, then IDLE.
- rst_n asserted while out_valid=1 mid-MCU -> outputs 0 immediately. The next frame starts at Y with an empty accumulator.

Source files
------------

// File: rtl/jpeg_stream_pkg.sv
// Shared types and constants for the JPEG multi-channel stream multiplexer.
package jpeg_stream_pkg;

  typedef enum logic [1:0] {
    MODE_444  = 2'd0,
    MODE_422  = 2'd1,
    MODE_420  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] EOI           = 8'hD9;
  localparam logic [7:0] STUFF         = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_MARKER_FF,
    ST_MARKER_D9
  } state_e;

  // Number of luma blocks per MCU; the reserved mode behaves like 4:4:4.
  function automatic logic [2:0] ny_of_mode(input mode_e mode);
    case (mode)
      MODE_422: return 3'd2;
      MODE_420: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/jpeg_stream_mux_bit_packer.sv
// MSB-first bit accumulator with byte extraction and 0xFF byte stuffing.
// Appended bits always land below the bits already held, so the top byte
// presented on out_data never changes while it waits for out_ready.
module bit_packer
  import jpeg_stream_pkg::*;
#(
  parameter int CODE_W = 27,
  parameter int LEN_W  = 5,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              append_en,
  input  logic [CODE_W-1:0] append_code,
  input  logic [LEN_W-1:0]  append_len,
  output logic              room,
  output logic              empty,
  output logic [2:0]        bit_phase,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stuff_q, stuff_d;

  logic [ACC_W-1:0]  acc_sh;
  logic [CNT_W-1:0]  cnt_sh;
  logic [CODE_W:0]   len_mask;
  logic [ACC_W-1:0]  word_ext;
  logic [CNT_W-1:0]  ins_pos;
  logic              pop_data;

  assign out_valid = stuff_q || (cnt_q >= CNT_W'(8));
  assign out_data  = stuff_q ? STUFF : (out_valid ? acc_q[ACC_W-1 -: 8] : 8'h00);
  assign room      = (cnt_q <= CNT_W'(ACC_W - CODE_W));
  assign empty     = (cnt_q == '0) && !stuff_q;
  assign bit_phase = cnt_q[2:0];

  // Pop the top byte on transfer, then append the new word just below the remaining bits.
  always_comb begin
    pop_data = out_valid && out_ready && !stuff_q;
    acc_sh   = acc_q;
    cnt_sh   = cnt_q;
    if (pop_data) begin
      acc_sh = acc_q << 8;
      cnt_sh = cnt_q - CNT_W'(8);
    end

    len_mask = ({{CODE_W{1'b0}}, 1'b1} << append_len) - (CODE_W + 1)'(1);
    word_ext = ACC_W'(append_code & len_mask[CODE_W-1:0]);
    ins_pos  = CNT_W'(ACC_W) - cnt_sh - CNT_W'(append_len);

    acc_d = acc_sh;
    cnt_d = cnt_sh;
    if (append_en) begin
      acc_d = acc_sh | (word_ext << ins_pos);
      cnt_d = cnt_sh + CNT_W'(append_len);
    end

    stuff_d = stuff_q;
    if (stuff_q && out_ready) begin
      stuff_d = 1'b0;
    end else if (pop_data && (acc_q[ACC_W-1 -: 8] == MARKER_PREFIX)) begin
      stuff_d = 1'b1;
    end
  end

  // Accumulator, bit count and stuff-pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      stuff_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stuff_q <= stuff_d;
    end
  end

endmodule

// File: rtl/jpeg_stream_mux.sv
// Interleaves CH entropy-coder streams per MCU, packs them into a stuffed
// JPEG byte stream and terminates each frame with padding plus EOI.
module jpeg_stream_mux
  import jpeg_stream_pkg::*;
#(
  parameter int CH     = 3,
  parameter int CODE_W = 27,
  parameter int LEN_W  = 5,
  parameter int ACC_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [CH-1:0]        in_valid,
  output logic [CH-1:0]        in_ready,
  input  logic [CH*CODE_W-1:0] in_code,
  input  logic [CH*LEN_W-1:0]  in_len,
  input  logic [CH-1:0]        in_eob,
  input  logic                 frame_end,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1;
  localparam int SLOTS_MAX = 4 + CH - 1;
  localparam int SLOT_W    = $clog2(SLOTS_MAX + 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               mid_q, mid_d;
  logic               pend_q, pend_d;

  logic [2:0]         ny;
  logic [SLOT_W-1:0]  last_slot;
  logic [CH_W-1:0]    sched_ch;
  logic [CODE_W-1:0]  sel_code;
  logic [LEN_W-1:0]   sel_len;
  logic               sel_eob;
  logic               run_ok;
  logic               accept;
  logic               pad_req;
  logic               marker;

  logic               pk_append_en;
  logic [CODE_W-1:0]  pk_code;
  logic [LEN_W-1:0]   pk_len;
  logic               pk_room;
  logic               pk_empty;
  logic [2:0]         pk_phase;
  logic               pk_valid;
  logic               pk_ready;
  logic [7:0]         pk_data;

  // Schedule decode: slots 0..NY-1 are luma, the remaining slots walk the chroma channels.
  always_comb begin
    ny        = ny_of_mode(mode_q);
    last_slot = SLOT_W'(ny) + SLOT_W'(CH) - SLOT_W'(2);
    if (slot_q < SLOT_W'(ny)) begin
      sched_ch = '0;
    end else begin
      sched_ch = CH_W'(slot_q - SLOT_W'(ny) + SLOT_W'(1));
    end
  end

  // Select the scheduled channel's word and grant only that channel.
  always_comb begin
    sel_code = '0;
    sel_len  = '0;
    sel_eob  = 1'b0;
    in_ready = '0;
    run_ok   = (state_q == ST_RUN) && pk_room && !(pend_q && !mid_q);
    for (int c = 0; c < CH; c++) begin
      if (sched_ch == CH_W'(c)) begin
        sel_code    = in_code[c*CODE_W +: CODE_W];
        sel_len     = in_len[c*LEN_W +: LEN_W];
        sel_eob     = in_eob[c];
        in_ready[c] = run_ok;
      end
    end
    accept = |(in_valid & in_ready);
  end

  // Feed the packer with accepted words, or with 1-bit padding while flushing.
  always_comb begin
    pad_req      = (state_q == ST_FLUSH) && (pk_phase != 3'd0);
    pk_append_en = accept || pad_req;
    pk_code      = '1;
    pk_len       = LEN_W'(8 - int'(pk_phase));
    if (accept) begin
      pk_code = sel_code;
      pk_len  = sel_len;
    end
  end

  // Output mux: packer bytes, or the unstuffed EOI marker pair.
  always_comb begin
    marker    = (state_q == ST_MARKER_FF) || (state_q == ST_MARKER_D9);
    pk_ready  = out_ready && !marker;
    out_valid = marker || pk_valid;
    out_data  = pk_data;
    out_last  = 1'b0;
    if (state_q == ST_MARKER_FF) begin
      out_data = MARKER_PREFIX;
    end else if (state_q == ST_MARKER_D9) begin
      out_data = EOI;
      out_last = 1'b1;
    end
    busy = (state_q != ST_IDLE);
  end

  // Frame sequencing: latch mode, walk the MCU schedule, then flush and emit EOI.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    slot_d  = slot_q;
    mid_d   = mid_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_valid) begin
          state_d = ST_RUN;
          mode_d  = (mode == 2'd3) ? MODE_444 : mode_e'(mode);
          slot_d  = '0;
          mid_d   = 1'b0;
          pend_d  = frame_end;
        end else if (frame_end) begin
          state_d = ST_FLUSH;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          pend_d = 1'b1;
        end
        if (accept) begin
          mid_d = 1'b1;
          if (sel_eob) begin
            if (slot_q == last_slot) begin
              slot_d = '0;
              mid_d  = 1'b0;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        if (pend_q && !mid_q) begin
          state_d = ST_FLUSH;
          pend_d  = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (pk_empty) begin
          state_d = ST_MARKER_FF;
        end
      end
      ST_MARKER_FF: begin
        if (out_ready) begin
          state_d = ST_MARKER_D9;
        end
      end
      ST_MARKER_D9: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          slot_d  = '0;
          mid_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and schedule registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_444;
      slot_q  <= '0;
      mid_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      slot_q  <= slot_d;
      mid_q   <= mid_d;
      pend_q  <= pend_d;
    end
  end

  bit_packer #(
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .append_en   (pk_append_en),
    .append_code (pk_code),
    .append_len  (pk_len),
    .room        (pk_room),
    .empty       (pk_empty),
    .bit_phase   (pk_phase),
    .out_valid   (pk_valid),
    .out_ready   (pk_ready),
    .out_data    (pk_data)
  );

endmodule

// File: tb/tb_jpeg_stream_mux.sv
// Randomised scoreboard bench for jpeg_stream_mux.
module tb_jpeg_stream_mux;

  localparam int CH     = 3;
  localparam int CODE_W = 27;
  localparam int LEN_W  = 5;
  localparam int ACC_W  = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           mode;
  logic [CH-1:0]        in_valid;
  logic [CH-1:0]        in_ready;
  logic [CH*CODE_W-1:0] in_code;
  logic [CH*LEN_W-1:0]  in_len;
  logic [CH-1:0]        in_eob;
  logic                 frame_end;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_last;
  logic                 busy;

  always #5 clk = ~clk;

  jpeg_stream_mux #(
    .CH     (CH),
    .CODE_W (CODE_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .in_eob    (in_eob),
    .frame_end (frame_end),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    int                ch;
    logic [CODE_W-1:0] code;
    int                len;
    bit                eob;
  } word_t;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } byte_t;

  word_t words[$];
  byte_t exp_q[$];
  int    ord_q[$];
  int    last_mcu_start;
  int    checks_total  = 0;
  int    checks_passed = 0;
  bit    frame_done    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic int nyOf(input logic [1:0] m);
    return (m == 2'd1) ? 2 : ((m == 2'd2) ? 4 : 1);
  endfunction

  function automatic int nextIdx(input int c, input int from);
    for (int i = from; i < words.size(); i++) begin
      if (words[i].ch == c) return i;
    end
    return -1;
  endfunction

  task automatic addWord(input int ch, input logic [CODE_W-1:0] code, input int len, input bit eob);
    word_t w;
    w.ch = ch; w.code = code; w.len = len; w.eob = eob;
    words.push_back(w);
  endtask

  // Words listed in MCU order: Y NY times, then each chroma channel once.
  task automatic genFrame(input logic [1:0] m, input int nmcu, input int min_len);
    int ch;
    int nw;
    word_t w;
    words.delete();
    last_mcu_start = 0;
    for (int u = 0; u < nmcu; u++) begin
      if (u == nmcu - 1) last_mcu_start = words.size();
      for (int s = 0; s < nyOf(m) + CH - 1; s++) begin
        ch = (s < nyOf(m)) ? 0 : s - nyOf(m) + 1;
        nw = $urandom_range(1, 3);
        for (int k = 0; k < nw; k++) begin
          w.ch   = ch;
          w.code = CODE_W'($urandom);
          w.len  = $urandom_range(min_len, CODE_W);
          if ($urandom_range(5) == 0) begin
            w.len = 8;
            w.code[7:0] = 8'hFF;
          end
          w.eob = (k == nw - 1);
          words.push_back(w);
        end
      end
    end
  endtask

  // Reference: concatenate bits, pad with ones, cut bytes, stuff after FF, add EOI.
  task automatic buildExpected();
    bit         bits[$];
    byte_t      b;
    logic [7:0] v;
    exp_q.delete();
    ord_q.delete();
    foreach (words[i]) begin
      for (int j = words[i].len - 1; j >= 0; j--) bits.push_back(words[i].code[j]);
      ord_q.push_back(words[i].ch);
    end
    while (bits.size() % 8 != 0) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k += 8) begin
      for (int j = 0; j < 8; j++) v[7-j] = bits[k+j];
      b.data = v; b.last = 1'b0;
      exp_q.push_back(b);
      if (v == 8'hFF) begin
        b.data = 8'h00;
        exp_q.push_back(b);
      end
    end
    b.data = 8'hFF; b.last = 1'b0; exp_q.push_back(b);
    b.data = 8'hD9; b.last = 1'b1; exp_q.push_back(b);
  endtask

  // Output monitor: every presented byte must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checkOutput("busy_when_out", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        checkOutput("extra_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        checkOutput("byte_data", 32'(out_data), 32'(exp_q[0].data));
        checkOutput("byte_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          if (exp_q[0].last) frame_done = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input int vpct, input int rdy_pct, input int stall,
                               input bit fe_mid, input bit fe_double, input bit abort);
    int n, trigger, acc_cnt, cyc, expch;
    int idx[CH];
    bit fe_sent, fe_again, stop;
    logic [CH-1:0] got;
    buildExpected();
    n = words.size();
    trigger = fe_mid ? last_mcu_start + 1 : n;
    if (n == 0) trigger = 0;
    frame_done = 1'b0;
    acc_cnt = 0; cyc = 0; fe_sent = 0; fe_again = 0; stop = 0;
    for (int c = 0; c < CH; c++) idx[c] = nextIdx(c, 0);
    @(posedge clk); #1;
    mode = m;
    while (!stop) begin
      for (int c = 0; c < CH; c++) begin
        if (idx[c] >= 0 && $urandom_range(99) < vpct) begin
          in_valid[c] = 1'b1;
          in_code[c*CODE_W +: CODE_W] = words[idx[c]].code;
          in_len[c*LEN_W +: LEN_W]    = LEN_W'(words[idx[c]].len);
          in_eob[c] = words[idx[c]].eob;
        end else begin
          in_valid[c] = 1'b0;
          in_code[c*CODE_W +: CODE_W] = CODE_W'($urandom);
          in_len[c*LEN_W +: LEN_W]    = LEN_W'($urandom_range(0, CODE_W));
          in_eob[c] = 1'($urandom);
        end
      end
      frame_end = 1'b0;
      if (fe_again) begin
        frame_end = 1'b1;
        fe_again  = 1'b0;
      end else if (!fe_sent && acc_cnt >= trigger) begin
        frame_end = 1'b1;
        fe_sent   = 1'b1;
        fe_again  = fe_double;
      end
      out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (acc_cnt > 0) mode = 2'($urandom);

      @(negedge clk);
      cyc++;
      expch = (ord_q.size() > 0) ? ord_q[0] : 0;
      checkOutput("ready_sched", 32'(in_ready & ~(CH'(1) << expch)), 32'd0);
      got = in_valid & in_ready;
      for (int c = 0; c < CH; c++) begin
        if (got[c]) begin
          checkOutput("accept_order", 32'(c), (ord_q.size() > 0) ? 32'(ord_q[0]) : 32'd99);
          if (ord_q.size() > 0) void'(ord_q.pop_front());
          idx[c] = nextIdx(c, idx[c] + 1);
          acc_cnt++;
        end
      end
      if (abort && acc_cnt > 0 && acc_cnt < n && out_valid) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        ord_q.delete();
        in_valid = '0; frame_end = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
      end else if (frame_done) begin
        stop = 1'b1;
      end else if (cyc >= 4000) begin
        checkOutput("frame_timeout", 32'd0, 32'd1);
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = '0;
    frame_end = 1'b0;
    if (!abort) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("drained", 32'(exp_q.size()), 32'd0);
      checkOutput("words_consumed", 32'(acc_cnt), 32'(n));
    end
  endtask

  initial begin
    in_valid = '0; in_code = '0; in_len = '0; in_eob = '0;
    frame_end = 1'b0; out_ready = 1'b0; mode = 2'd0;
    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_last", 32'(out_last), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] 4:4:4 directed frame");
    words.delete();
    addWord(0, 27'b1010, 4, 1'b1);
    addWord(1, 27'b0101, 4, 1'b1);
    addWord(2, 27'hFF, 8, 1'b1);
    last_mcu_start = 0;
    applyStimulus(2'd0, 100, 100, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] partial byte padding");
    words.delete();
    addWord(0, 27'b101, 3, 1'b1);
    addWord(1, 27'h5A5A5A5, 0, 1'b1);
    addWord(2, 27'h7FFFFFF, 0, 1'b1);
    last_mcu_start = 0;
    applyStimulus(2'd0, 100, 100, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] frame_end in idle");
    words.delete();
    last_mcu_start = 0;
    applyStimulus(2'd0, 100, 100, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] 4:2:0 ordering");
    genFrame(2'd2, 2, 0);
    applyStimulus(2'd2, 100, 100, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] output backpressure");
    genFrame(2'd0, 3, 20);
    applyStimulus(2'd0, 100, 100, 20, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    genFrame(2'd1, 2, 16);
    applyStimulus(2'd1, 100, 50, 0, 1'b0, 1'b0, 1'b1);
    genFrame(2'd0, 1, 0);
    applyStimulus(2'd0, 80, 80, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reserved mode");
    genFrame(2'd3, 2, 0);
    applyStimulus(2'd3, 90, 90, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 25; f++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      genFrame(m, $urandom_range(0, 3), 0);
      applyStimulus(m, $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 10),
                    1'($urandom), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
